// File: rtl/ps2_frame_rx.sv
//==============================================================================
// Module      : ps2_frame_rx
// Description : PS/2 device-to-host receiver; syncs and de-glitches ps2c/ps2d,
//               deserialises 11-bit frames and strobes good bytes or errors.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_frame_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en_i,
  output logic [7:0] rx_data_o,
  output logic       rx_done_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int                c_TO_W   = $clog2(TIMEOUT_CYC);
  localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT_CYC - 1);
  localparam logic [c_TO_W-1:0] c_TO_ONE = c_TO_W'(1);
  localparam logic [3:0]        c_LAST_BIT = 4'd9;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Input synchronisers and clock de-glitch filter
  logic                  r_c_meta;
  logic                  r_c_sync;
  logic                  r_d_meta;
  logic                  r_d_sync;
  logic [FILTER_LEN-1:0] r_filt_sr;
  logic                  r_fclk;
  logic                  r_fclk_d;
  logic                  w_fall_tick;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_c_meta  <= 1'b1;
      r_c_sync  <= 1'b1;
      r_d_meta  <= 1'b1;
      r_d_sync  <= 1'b1;
      r_filt_sr <= '1;
      r_fclk    <= 1'b1;
      r_fclk_d  <= 1'b1;
    end else begin
      r_c_meta  <= ps2c;
      r_c_sync  <= r_c_meta;
      r_d_meta  <= ps2d;
      r_d_sync  <= r_d_meta;
      r_filt_sr <= {r_filt_sr[FILTER_LEN-2:0], r_c_sync};
      if (&r_filt_sr) begin
        r_fclk <= 1'b1;
      end else if (~|r_filt_sr) begin
        r_fclk <= 1'b0;
      end
      r_fclk_d  <= r_fclk;
    end
  end

  assign w_fall_tick = r_fclk_d & ~r_fclk;

  // Receive state machine
  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_bit_cnt;
  logic [3:0]          w_bit_cnt_nxt;
  logic [c_TO_W-1:0]   r_to_cnt;
  logic [c_TO_W-1:0]   w_to_cnt_nxt;
  logic [8:0]          r_shift;
  logic [8:0]          w_shift_nxt;
  logic [7:0]          r_data;
  logic [7:0]          w_data_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic                r_perr;
  logic                w_perr_nxt;
  logic                r_ferr;
  logic                w_ferr_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic [9:0]          w_frame;

  // The stop bit is taken straight from the pin, so only 9 bits are stored.
  assign w_frame = {r_d_sync, r_shift};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 4'd0;
      r_to_cnt  <= '0;
      r_shift   <= 9'd0;
      r_data    <= 8'h00;
      r_done    <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_data    <= w_data_nxt;
      r_done    <= w_done_nxt;
      r_perr    <= w_perr_nxt;
      r_ferr    <= w_ferr_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_to_cnt_nxt  = r_to_cnt;
    w_shift_nxt   = r_shift;
    w_data_nxt    = r_data;
    w_done_nxt    = 1'b0;
    w_perr_nxt    = 1'b0;
    w_ferr_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_fall_tick && rx_en_i && !r_d_sync) begin
          w_state_nxt   = ST_SHIFT;
          w_bit_cnt_nxt = 4'd0;
          w_to_cnt_nxt  = '0;
        end
      end
      ST_SHIFT: begin
        if (w_fall_tick) begin
          // An edge coinciding with the terminal count still wins.
          w_shift_nxt   = w_frame[9:1];
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          w_to_cnt_nxt  = '0;
          if (r_bit_cnt == c_LAST_BIT) begin
            w_state_nxt = ST_IDLE;
            if (!w_frame[9]) begin
              w_ferr_nxt = 1'b1;
            end else if (^w_frame[8:0]) begin
              w_done_nxt = 1'b1;
              w_data_nxt = w_frame[7:0];
            end else begin
              w_perr_nxt = 1'b1;
            end
          end
        end else if (r_to_cnt == c_TO_MAX) begin
          w_state_nxt = ST_IDLE;
          w_ferr_nxt  = 1'b1;
        end else begin
          w_to_cnt_nxt = r_to_cnt + c_TO_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == ST_SHIFT);
  end

  assign rx_data_o    = r_data;
  assign rx_done_o    = r_done;
  assign parity_err_o = r_perr;
  assign frame_err_o  = r_ferr;
  assign busy_o       = r_busy;

endmodule

`default_nettype wire
